pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC/target width (>=28).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-003 SHALL have parameter EXC_VEC, default 32'h0000_4180, exception handler entry.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-stack entries (power of 2, >=2).
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port stall  in  1  hold PC (hazard freeze).
REQ-008 SHALL have port exc_req  in  1  redirect to EXC_VEC.
REQ-009 SHALL have port id_pc4  in  ADDR_W  PC+4 of the redirecting instruction.
REQ-010 SHALL have port br_taken  in  1  conditional branch resolved taken.
REQ-011 SHALL have port br_imm  in  16  signed word offset.
REQ-012 SHALL have port j_valid  in  1  j/jal redirect.
REQ-013 SHALL have port j_index  in  26  jump index field.
REQ-014 SHALL have port call  in  1  qualifies j_valid as jal (RAS push).
REQ-015 SHALL have port jr_valid  in  1  register-indirect redirect.
REQ-016 SHALL have port jr_target  in  ADDR_W  register target.
REQ-017 SHALL have port ret  in  1  qualifies jr_valid as return (RAS pop).
REQ-018 SHALL have port pc  out  ADDR_W  current fetch PC (registered).
REQ-019 SHALL have port pc4  out  ADDR_W  pc+4, combinational.
REQ-020 SHALL have port pc_misalign  out  1  pc[1:0]!=0, combinational.
REQ-021 SHALL have port ras_miss  out  1  registered, one-cycle return-prediction miss pulse.
REQ-022 SHALL have port ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries.

Function
REQ-023 SHALL select next PC by priority: exc_req > stall(hold) > jr_valid > j_valid > br_taken > pc+4.
REQ-024 SHALL compute branch target = id_pc4 + (sign-extended br_imm << 2), modulo 2^ADDR_W.
REQ-025 SHALL compute jump target = {id_pc4[ADDR_W-1:28], j_index, 2'b00}.
REQ-026 SHALL load jr_target unmodified; misaligned value loads and pc_misalign asserts while pc holds it.
REQ-027 SHALL update pc every cycle with one-cycle latency (selected target visible the cycle after inputs).
REQ-028 SHALL, on exc_req, load EXC_VEC even when stall=1, with no RAS update.
REQ-029 SHALL, on stall (no exc_req), hold pc and leave RAS and ras_miss=0 unchanged/cleared.
REQ-030 SHALL push id_pc4+4 onto RAS when j_valid&call is the selected redirect.
REQ-031 SHALL, on push when full, overwrite oldest entry (circular), ras_count stays RAS_DEPTH.
REQ-032 SHALL pop RAS when jr_valid&ret is selected; ras_miss=1 next cycle if empty or top!=jr_target.
REQ-033 SHALL leave RAS unchanged and ras_count at 0 on pop when empty.
REQ-034 SHALL never push and pop in the same cycle (jr priority excludes j).

Reset
REQ-035 SHALL on reset set pc=RESET_PC, ras_count=0, ras_miss=0, overriding all other inputs.
REQ-036 SHALL treat reset asserted mid-stall or mid-redirect identically (no pending state survives).

Configuration
REQ-037 SHALL compile RAS logic only when PC_SEQ_RAS_EN is defined.
REQ-038 SHALL, without PC_SEQ_RAS_EN, tie ras_miss=0 and ras_count=0, ignore call/ret; PC behaviour unchanged.

Verification
REQ-039 SHALL check: reset, then 3 free cycles -> pc 0x3000,0x3004,0x3008,0x300C.
REQ-040 SHALL check: br_taken, id_pc4=0x3008, br_imm=0xFFFF -> pc=0x3004 next cycle.
REQ-041 SHALL check: j_valid, id_pc4=0x3004, j_index=0x0000C10 -> pc=0x00003040.
REQ-042 SHALL check: stall=1 with jr_valid and exc_req=1 -> pc=0x4180; stall alone 2 cycles -> pc held.
REQ-043 SHALL check (RAS_EN): jal at id_pc4=0x3010 -> ras_count=1; jr ret target 0x3014 -> ras_miss=0, count=0; repeat with 0x3018 -> ras_miss=1.
REQ-044 SHALL check (RAS_EN): 5 calls at depth 4 -> ras_count=4, oldest lost; 5 returns -> fifth gives ras_miss=1, count=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch PC sequencer with prioritised redirects and optional return
//            address stack (enabled by defining PC_SEQ_RAS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_4180),
    parameter int                RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         exc_req,
    input  logic [ADDR_W-1:0]            id_pc4,
    input  logic                         br_taken,
    input  logic [15:0]                  br_imm,
    input  logic                         j_valid,
    input  logic [25:0]                  j_index,
    input  logic                         call,
    input  logic                         jr_valid,
    input  logic [ADDR_W-1:0]            jr_target,
    input  logic                         ret,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            pc4,
    output logic                         pc_misalign,
    output logic                         ras_miss,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int c_PTR_W = $clog2(RAS_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;

    assign pc          = pc_q;
    assign pc4         = pc_q + ADDR_W'(4);
    assign pc_misalign = |pc_q[1:0];
    assign br_target   = id_pc4 + {{(ADDR_W-18){br_imm[15]}}, br_imm, 2'b00};

    generate
        if (ADDR_W > 28) begin : g_jt_region
            assign j_target = {id_pc4[ADDR_W-1:28], j_index, 2'b00};
        end else begin : g_jt_flat
            assign j_target = {j_index, 2'b00};
        end
    endgenerate

    always_comb begin
        pc_d = pc4;
        if (exc_req)       pc_d = EXC_VEC;
        else if (stall)    pc_d = pc_q;
        else if (jr_valid) pc_d = jr_target;
        else if (j_valid)  pc_d = j_target;
        else if (br_taken) pc_d = br_target;
    end

    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

`ifdef PC_SEQ_RAS_EN
    logic [ADDR_W-1:0]  ras_mem_q [RAS_DEPTH];
    logic [ADDR_W-1:0]  ras_mem_d [RAS_DEPTH];
    logic [c_PTR_W-1:0] ptr_q, ptr_d, ptr_prev;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               miss_q, miss_d;
    logic               push, pop;

    // jr outranks j in the selector, so push and pop are mutually exclusive
    assign push     = !exc_req && !stall && !jr_valid && j_valid && call;
    assign pop      = !exc_req && !stall && jr_valid && ret;
    assign ptr_prev = ptr_q - c_PTR_W'(1);

    always_comb begin
        ras_mem_d = ras_mem_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        miss_d    = 1'b0;
        if (push) begin
            // ptr_q always addresses the oldest slot once full, so wrap overwrites it
            ras_mem_d[ptr_q] = id_pc4 + ADDR_W'(4);
            ptr_d            = ptr_q + c_PTR_W'(1);
            if (cnt_q != c_CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + c_CNT_W'(1);
        end else if (pop) begin
            if (cnt_q == '0) begin
                miss_d = 1'b1;
            end else begin
                miss_d = (ras_mem_q[ptr_prev] != jr_target);
                ptr_d  = ptr_prev;
                cnt_d  = cnt_q - c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            miss_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            miss_q <= miss_d;
        end
    end

    always_ff @(posedge clk) begin
        ras_mem_q <= ras_mem_d;
    end

    assign ras_miss  = miss_q;
    assign ras_count = cnt_q;
`else
    logic w_unused_ras;
    assign w_unused_ras = ^{call, ret};
    assign ras_miss     = 1'b0;
    assign ras_count    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed self-checking bench for pc_sequencer (RAS checks when
//            PC_SEQ_RAS_EN is defined, tie-off checks otherwise).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, exc_req, br_taken, j_valid, call, jr_valid, ret;
    logic [31:0] id_pc4, jr_target;
    logic [15:0] br_imm;
    logic [25:0] j_index;
    logic [31:0] pc, pc4;
    logic        pc_misalign, ras_miss;
    logic [2:0]  ras_count;

    int vectors = 0;
    int errors  = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .exc_req(exc_req),
        .id_pc4(id_pc4), .br_taken(br_taken), .br_imm(br_imm),
        .j_valid(j_valid), .j_index(j_index), .call(call),
        .jr_valid(jr_valid), .jr_target(jr_target), .ret(ret),
        .pc(pc), .pc4(pc4), .pc_misalign(pc_misalign),
        .ras_miss(ras_miss), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        reset = 0; stall = 0; exc_req = 0; br_taken = 0; j_valid = 0;
        call = 0; jr_valid = 0; ret = 0; id_pc4 = 0; jr_target = 0;
        br_imm = 0; j_index = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step(); step();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h3000); end
        vectors++; if (pc4 !== 32'h3004) begin errors++; $display("FAIL reset_pc4 got %h exp %h", pc4, 32'h3004); end
        vectors++; if (ras_count !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", ras_count); end
        vectors++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL reset_miss got %b exp 0", ras_miss); end
        vectors++; if (pc_misalign !== 1'b0) begin errors++; $display("FAIL reset_mis got %b exp 0", pc_misalign); end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h3004; exp_pc[1] = 32'h3008; exp_pc[2] = 32'h300C;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL free_run[%0d] got %h exp %h", i, pc, exp_pc[i]); end
        end
    endtask

    task automatic test_branch();
        br_taken = 1; id_pc4 = 32'h3008; br_imm = 16'hFFFF;
        step();
        vectors++; if (pc !== 32'h3004) begin errors++; $display("FAIL branch_back got %h exp %h", pc, 32'h3004); end
        id_pc4 = 32'h1000; br_imm = 16'h0010;
        step();
        vectors++; if (pc !== 32'h1040) begin errors++; $display("FAIL branch_fwd got %h exp %h", pc, 32'h1040); end
        id_pc4 = 32'h0000_0004; br_imm = 16'h8000;
        step();
        vectors++; if (pc !== 32'hFFFE_0004) begin errors++; $display("FAIL branch_wrap got %h exp %h", pc, 32'hFFFE_0004); end
        idle();
    endtask

    task automatic test_jump();
        j_valid = 1; id_pc4 = 32'h3004; j_index = 26'h0000C10;
        step();
        vectors++; if (pc !== 32'h0000_3040) begin errors++; $display("FAIL jump got %h exp %h", pc, 32'h3040); end
        id_pc4 = 32'hA000_0000; j_index = 26'h3FFFFFF;
        step();
        vectors++; if (pc !== 32'hAFFF_FFFC) begin errors++; $display("FAIL jump_region got %h exp %h", pc, 32'hAFFF_FFFC); end
        idle();
    endtask

    task automatic test_exc_stall();
        stall = 1; jr_valid = 1; jr_target = 32'h7000; exc_req = 1;
        step();
        vectors++; if (pc !== 32'h4180) begin errors++; $display("FAIL exc_over_stall got %h exp %h", pc, 32'h4180); end
        idle(); stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++; if (pc !== 32'h4180) begin errors++; $display("FAIL stall_hold[%0d] got %h exp %h", i, pc, 32'h4180); end
        end
        stall = 1; jr_valid = 1; jr_target = 32'h7000; br_taken = 1;
        step();
        vectors++; if (pc !== 32'h4180) begin errors++; $display("FAIL stall_over_jr got %h exp %h", pc, 32'h4180); end
        idle();
        step();
        vectors++; if (pc !== 32'h4184) begin errors++; $display("FAIL stall_release got %h exp %h", pc, 32'h4184); end
    endtask

    task automatic test_priority();
        jr_valid = 1; jr_target = 32'h5002; j_valid = 1; j_index = 26'h10; br_taken = 1; br_imm = 16'h4;
        step();
        vectors++; if (pc !== 32'h5002) begin errors++; $display("FAIL jr_prio got %h exp %h", pc, 32'h5002); end
        vectors++; if (pc_misalign !== 1'b1) begin errors++; $display("FAIL misalign got %b exp 1", pc_misalign); end
        vectors++; if (pc4 !== 32'h5006) begin errors++; $display("FAIL misalign_pc4 got %h exp %h", pc4, 32'h5006); end
        jr_valid = 0; id_pc4 = 32'h2000;
        step();
        vectors++; if (pc !== 32'h0000_0040) begin errors++; $display("FAIL j_over_br got %h exp %h", pc, 32'h40); end
        vectors++; if (pc_misalign !== 1'b0) begin errors++; $display("FAIL aligned got %b exp 0", pc_misalign); end
        idle();
    endtask

    task automatic test_reset_mid_redirect();
        stall = 1; step();
        reset = 1; exc_req = 1; jr_valid = 1; jr_target = 32'h9000;
        step();
        vectors++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_over_exc got %h exp %h", pc, 32'h3000); end
        idle();
        step();
        vectors++; if (pc !== 32'h3004) begin errors++; $display("FAIL post_reset got %h exp %h", pc, 32'h3004); end
    endtask

`ifdef PC_SEQ_RAS_EN
    task automatic test_ras_basic();
        do_reset();
        j_valid = 1; call = 1; id_pc4 = 32'h3010; j_index = 26'hC10;
        step();
        vectors++; if (ras_count !== 3'd1) begin errors++; $display("FAIL jal_cnt got %0d exp 1", ras_count); end
        idle(); jr_valid = 1; ret = 1; jr_target = 32'h3014;
        step();
        vectors++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL ret_hit_miss got %b exp 0", ras_miss); end
        vectors++; if (ras_count !== 3'd0) begin errors++; $display("FAIL ret_hit_cnt got %0d exp 0", ras_count); end
        idle(); j_valid = 1; call = 1; id_pc4 = 32'h3010;
        step();
        idle(); jr_valid = 1; ret = 1; jr_target = 32'h3018;
        step();
        vectors++; if (ras_miss !== 1'b1) begin errors++; $display("FAIL ret_wrong got %b exp 1", ras_miss); end
        idle();
        step();
        vectors++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL miss_pulse got %b exp 0", ras_miss); end
        // exception and stall must not touch the stack
        exc_req = 1; j_valid = 1; call = 1; id_pc4 = 32'h100;
        step();
        idle(); stall = 1; j_valid = 1; call = 1;
        step();
        vectors++; if (ras_count !== 3'd0) begin errors++; $display("FAIL exc_stall_nopush got %0d exp 0", ras_count); end
        idle();
    endtask

    task automatic test_ras_overflow();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            j_valid = 1; call = 1; id_pc4 = 32'(k * 32'h100);
            step();
        end
        idle();
        vectors++; if (ras_count !== 3'd4) begin errors++; $display("FAIL full_cnt got %0d exp 4", ras_count); end
        for (int k = 5; k >= 1; k--) begin
            jr_valid = 1; ret = 1; jr_target = 32'(k * 32'h100 + 4);
            step();
            vectors++;
            if (ras_miss !== (k == 1)) begin errors++; $display("FAIL pop[%0d] miss got %b exp %b", k, ras_miss, (k == 1)); end
        end
        idle();
        vectors++; if (ras_count !== 3'd0) begin errors++; $display("FAIL drained_cnt got %0d exp 0", ras_count); end
    endtask
`else
    task automatic test_no_ras();
        do_reset();
        j_valid = 1; call = 1; id_pc4 = 32'h3010; j_index = 26'hC10;
        step();
        vectors++; if (ras_count !== 3'd0) begin errors++; $display("FAIL noras_cnt got %0d exp 0", ras_count); end
        vectors++; if (pc !== 32'h3040) begin errors++; $display("FAIL noras_jal_pc got %h exp %h", pc, 32'h3040); end
        idle(); jr_valid = 1; ret = 1; jr_target = 32'h3018;
        step();
        vectors++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL noras_miss got %b exp 0", ras_miss); end
        vectors++; if (pc !== 32'h3018) begin errors++; $display("FAIL noras_ret_pc got %h exp %h", pc, 32'h3018); end
        idle();
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_free_run();
        test_branch();
        test_jump();
        test_exc_stall();
        test_priority();
        test_reset_mid_redirect();
`ifdef PC_SEQ_RAS_EN
        test_ras_basic();
        test_ras_overflow();
`else
        test_no_ras();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
